// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multicycle RV32I control FSM with memory ready handshakes and timeout.
// Define ILLEGAL_TRAP_EN to trap unknown opcodes (adds illegal_instr); otherwise they execute as NOPs.
module multicycle_control_unit #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opCode,
  input  logic [2:0] fun3,
  input  logic [6:0] fun7,
  input  logic       im_ready,
  input  logic       dm_ready,
  output logic       IMReq,
  output logic       IRWr,
  output logic       PCWr,
  output logic       DMReq,
  output logic       DMWr,
  output logic [2:0] DMCtrl,
  output logic [2:0] ImmSrc,
  output logic       ALUASrc,
  output logic       ALUBSrc,
  output logic [3:0] ALUOpcode,
  output logic [4:0] BrOp,
  output logic [1:0] RUDataWrSrc,
  output logic       RUWr,
  output logic       bus_error,
  output logic [2:0] state_o
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic       illegal_instr
`endif
);
  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIM = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
    OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
  typedef enum logic [2:0] {
    FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, HALT = 3'd5, TRAP = 3'd6
  } state_e;
  state_e state_q, state_d;
  logic [6:0] op_q, op_d;
  logic [2:0] f3_q, f3_d;
  logic f7b_q, f7b_d, bus_q, bus_d, waiting, timeout;
  logic [CW-1:0] cnt_q, cnt_d;
  logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, alu_a, alu_b;
  logic [3:0] alu_op;
  logic [2:0] imm;
  logic unused_fun7;
  assign unused_fun7 = ^{fun7[6], fun7[4:0]};
  function automatic logic known(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR};
  endfunction
  assign is_r    = op_q == OP_R;
  assign is_i    = op_q == OP_I;
  assign is_ld   = op_q == OP_LD;
  assign is_st   = op_q == OP_ST;
  assign is_br   = op_q == OP_BR;
  assign is_jal  = op_q == OP_JAL;
  assign is_jalr = op_q == OP_JALR;
  // ALU controls set up in EXEC and held through MEM (and WB for jumps)
  assign alu_a  = is_br | is_jal;
  assign alu_b  = is_i | is_ld | is_st | is_br | is_jal | is_jalr;
  assign alu_op = is_r ? {f7b_q, f3_q} : is_i ? {(f3_q == 3'b101) & f7b_q, f3_q} : 4'b0000;
  assign imm    = is_st ? 3'b001 : is_br ? 3'b101 : is_jal ? 3'b110 : 3'b000;
  assign waiting = (state_q == FETCH && !im_ready) || (state_q == MEM && !dm_ready);
  assign timeout = (MEM_TIMEOUT > 0) && waiting && cnt_q == LIM;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
      op_q    <= '0;
      f3_q    <= '0;
      f7b_q   <= 1'b0;
      cnt_q   <= '0;
      bus_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      f3_q    <= f3_d;
      f7b_q   <= f7b_d;
      cnt_q   <= cnt_d;
      bus_q   <= bus_d;
    end
  end
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    f3_d = f3_q;
    f7b_d = f7b_q;
    bus_d = bus_q;
    IMReq = 1'b0;
    IRWr = 1'b0;
    PCWr = 1'b0;
    DMReq = 1'b0;
    DMWr = 1'b0;
    DMCtrl = 3'b000;
    ImmSrc = 3'b000;
    ALUASrc = 1'b0;
    ALUBSrc = 1'b0;
    ALUOpcode = 4'b0000;
    BrOp = 5'b00000;
    RUDataWrSrc = 2'b00;
    RUWr = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    illegal_instr = 1'b0;
`endif
    case (state_q)
      FETCH: begin
        IMReq = 1'b1;
        IRWr = im_ready;
        state_d = im_ready ? DECODE : timeout ? HALT : FETCH;
        bus_d = bus_q | timeout;
      end
      DECODE: begin
        op_d = opCode;
        f3_d = fun3;
        f7b_d = fun7[5];
`ifdef ILLEGAL_TRAP_EN
        state_d = known(opCode) ? EXEC : TRAP;
`else
        state_d = EXEC;
`endif
      end
      EXEC: begin
        ImmSrc = imm;
        ALUASrc = alu_a;
        ALUBSrc = alu_b;
        ALUOpcode = alu_op;
        BrOp = is_br ? {2'b00, f3_q} : 5'b00000;
        PCWr = is_br | !known(op_q);
        state_d = (is_ld | is_st) ? MEM : (is_br | !known(op_q)) ? FETCH : WB;
      end
      MEM: begin
        ImmSrc = imm;
        ALUASrc = alu_a;
        ALUBSrc = alu_b;
        ALUOpcode = alu_op;
        DMReq = 1'b1;
        DMCtrl = f3_q;
        DMWr = is_st;
        PCWr = dm_ready & is_st;
        state_d = dm_ready ? (is_st ? FETCH : WB) : timeout ? HALT : MEM;
        bus_d = bus_q | timeout;
      end
      WB: begin
        RUWr = 1'b1;
        PCWr = 1'b1;
        RUDataWrSrc = is_ld ? 2'b01 : (is_jal | is_jalr) ? 2'b10 : 2'b00;
        BrOp = (is_jal | is_jalr) ? 5'b11111 : 5'b00000;
        ImmSrc = (is_jal | is_jalr) ? imm : 3'b000;
        ALUASrc = (is_jal | is_jalr) & alu_a;
        ALUBSrc = (is_jal | is_jalr) & alu_b;
        ALUOpcode = (is_jal | is_jalr) ? alu_op : 4'b0000;
        state_d = FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      TRAP: illegal_instr = 1'b1;
`endif
      default: ;
    endcase
    cnt_d = (state_d == state_q && waiting) ? cnt_q + 1'b1 : '0;
    if (!rst_n) begin
      IMReq = 1'b0;
      IRWr = 1'b0;
      PCWr = 1'b0;
      DMReq = 1'b0;
      DMWr = 1'b0;
      DMCtrl = 3'b000;
      ImmSrc = 3'b000;
      ALUASrc = 1'b0;
      ALUBSrc = 1'b0;
      ALUOpcode = 4'b0000;
      BrOp = 5'b00000;
      RUDataWrSrc = 2'b00;
      RUWr = 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal_instr = 1'b0;
`endif
    end
  end
  assign bus_error = rst_n & bus_q;
  assign state_o = rst_n ? state_q : 3'd0;
endmodule
